note_player: RTL

Consumes the note stream issued by the song sequencer and turns each note into a phase-increment (step size) for the sine sample generator. For each note it holds the step size for `duration` beats, then pulses `note_done` back to the sequencer. It is the responder end of the sequencer's new_note/note_done handshake and sits between the song sequencer and the sine reader in the music player.

---
 rtl/music_defs.sv | 18 +
 rtl/enable_dff.sv | 20 ++
 rtl/frequency_rom.sv | 37 +++
 rtl/note_player.sv | 113 +++++++++++
 4 files changed

// File: rtl/music_defs.sv
// Shared definitions for the music player: bus widths, note-player state
// encodings and the rest-note index.
package music_defs;

    localparam int STEP_W = 20;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        NP_IDLE    = 2'd0,
        NP_LOAD    = 2'd1,
        NP_PLAYING = 2'd2,
        NP_DONE    = 2'd3
    } np_state_t;

endpackage

// File: rtl/enable_dff.sv
// Generic enable flop cell with asynchronous active-low reset to zero.
module enable_dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/frequency_rom.sv
// Note-index to phase-increment ROM with registered output (1-cycle latency).
// Entry k = round(f(k) * 2^20 / 48000) with f(49) = 440 Hz, equal temperament.
module frequency_rom #(
    parameter int STEP_W = music_defs::STEP_W,
    parameter int NOTE_W = music_defs::NOTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] addr,
    output logic [STEP_W-1:0] data
);
    import music_defs::*;

    localparam logic [19:0] STEP_TABLE [64] = '{
        20'd0,
        20'd601,   20'd636,   20'd674,   20'd714,   20'd757,   20'd802,
        20'd850,   20'd900,   20'd954,   20'd1010,  20'd1070,  20'd1134,
        20'd1201,  20'd1273,  20'd1349,  20'd1429,  20'd1514,  20'd1604,
        20'd1699,  20'd1800,  20'd1907,  20'd2021,  20'd2141,  20'd2268,
        20'd2403,  20'd2546,  20'd2697,  20'd2858,  20'd3028,  20'd3208,
        20'd3398,  20'd3600,  20'd3815,  20'd4041,  20'd4282,  20'd4536,
        20'd4806,  20'd5092,  20'd5395,  20'd5715,  20'd6055,  20'd6415,
        20'd6797,  20'd7201,  20'd7629,  20'd8083,  20'd8563,  20'd9072,
        20'd9612,  20'd10184, 20'd10789, 20'd11431, 20'd12110, 20'd12830,
        20'd13593, 20'd14402, 20'd15258, 20'd16165, 20'd17127, 20'd18145,
        20'd19224, 20'd20367, 20'd21578
    };

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= '0;
        end else begin
            data <= STEP_W'(STEP_TABLE[addr]);
        end
    end

endmodule

// File: rtl/note_player.sv
// Responder end of the sequencer's new_note/note_done handshake: turns each
// note into a sine-reader step size held for the note's duration in beats.
module note_player #(
    parameter int STEP_W = music_defs::STEP_W,
    parameter int NOTE_W = music_defs::NOTE_W,
    parameter int DUR_W  = music_defs::DUR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              beat,
    input  logic              new_note,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    output logic [STEP_W-1:0] step_size,
    output logic              note_done,
    output logic              busy
);
    import music_defs::*;

    np_state_t         state;
    logic [NOTE_W-1:0] note_q;
    logic [DUR_W-1:0]  dur_q;
    logic [DUR_W-1:0]  count;
    logic [NOTE_W-1:0] rom_addr;
    logic [STEP_W-1:0] rom_data;

    enable_dff #(.W(NOTE_W)) u_note_latch (
        .clk   (clk),
        .reset (reset),
        .en    (new_note),
        .d     (note),
        .q     (note_q)
    );

    enable_dff #(.W(DUR_W)) u_dur_latch (
        .clk   (clk),
        .reset (reset),
        .en    (new_note),
        .d     (duration),
        .q     (dur_q)
    );

    // Reading the live note on the strobe lets the ROM result be ready at the
    // end of LOAD, so step_size is valid two cycles after the strobe.
    assign rom_addr = new_note ? note : note_q;

    frequency_rom #(
        .STEP_W (STEP_W),
        .NOTE_W (NOTE_W)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  (rom_addr),
        .data  (rom_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= NP_IDLE;
            count     <= '0;
            step_size <= '0;
            note_done <= 1'b0;
            busy      <= 1'b0;
        end else if (new_note) begin
            // A new note preempts whatever is playing; the old one never completes.
            state     <= NP_LOAD;
            busy      <= 1'b1;
            note_done <= 1'b0;
        end else begin
            note_done <= 1'b0;
            case (state)
                NP_IDLE: begin
                    state <= NP_IDLE;
                end
                NP_LOAD: begin
                    if (play) begin
                        if (dur_q == '0) begin
                            state     <= NP_DONE;
                            note_done <= 1'b1;
                            step_size <= '0;
                            busy      <= 1'b0;
                        end else begin
                            state     <= NP_PLAYING;
                            count     <= dur_q;
                            step_size <= rom_data;
                        end
                    end
                end
                NP_PLAYING: begin
                    if (play && beat) begin
                        if (count == DUR_W'(1)) begin
                            state     <= NP_DONE;
                            count     <= '0;
                            note_done <= 1'b1;
                            step_size <= '0;
                            busy      <= 1'b0;
                        end else begin
                            count <= count - DUR_W'(1);
                        end
                    end
                end
                NP_DONE: begin
                    state <= NP_IDLE;
                end
                default: begin
                    state <= NP_IDLE;
                end
            endcase
        end
    end

endmodule
